// File: rtl/alu_bist_driver.sv
// Self-test sequencer for the W0RM ALU: issues LFSR-generated operations,
// checks each result against a built-in golden model and reports pass/fail.
module alu_bist_driver #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
    parameter int          TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  alu_valid,
    output logic [2:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_result_valid,
    output logic                  done,
    output logic                  error,
    output logic                  timeout,
    output logic [7:0]            fail_count,
    output logic [7:0]            first_fail
);
    localparam int SHW = $clog2(DATA_WIDTH);

    // Right-shifting Galois feedback masks; unknown widths fall back to x^N+1.
    function automatic logic [DATA_WIDTH-1:0] tap_mask();
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        case (DATA_WIDTH)
            8:       m = DATA_WIDTH'(8'hB8);
            16:      m = DATA_WIDTH'(16'hB400);
            32:      m = DATA_WIDTH'(32'h8020_0003);
            64:      m = DATA_WIDTH'(64'hD800_0000_0000_0000);
            default: begin
                m[DATA_WIDTH-1] = 1'b1;
                m[0]            = 1'b1;
            end
        endcase
        return m;
    endfunction

    localparam logic [DATA_WIDTH-1:0] MASK      = tap_mask();
    localparam logic [DATA_WIDTH-1:0] SEED_RAW  = DATA_WIDTH'(LFSR_SEED);
    localparam logic [DATA_WIDTH-1:0] SEED      = (SEED_RAW == '0) ? DATA_WIDTH'(1) : SEED_RAW;
    localparam logic [7:0]            LAST_IDX  = 8'(NUM_VECTORS - 1);
    localparam logic [7:0]            WAIT_MAX  = 8'(TIMEOUT);

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] x);
        return (x >> 1) ^ (x[0] ? MASK : '0);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] lfsr_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic [7:0]            index_reg;
    logic [7:0]            wait_cnt_reg;

    logic [DATA_WIDTH-1:0] a_next;
    logic [DATA_WIDTH-1:0] b_next;
    logic [DATA_WIDTH-1:0] lfsr_next;
    logic [DATA_WIDTH-1:0] golden;
    logic [SHW-1:0]        shamt;
    logic [7:0]            wait_inc;

    // A new run restarts from the seed; later vectors continue the sequence.
    assign a_next    = (state_reg == ST_CHECK) ? lfsr_reg : SEED;
    assign b_next    = lfsr_step(a_next);
    assign lfsr_next = lfsr_step(b_next);
    assign shamt     = alu_b[SHW-1:0];
    assign wait_inc  = wait_cnt_reg + 8'd1;

    always_comb begin
        golden = '0;
        case (alu_op)
            3'd0:    golden = alu_a + alu_b;
            3'd1:    golden = alu_a - alu_b;
            3'd2:    golden = alu_a & alu_b;
            3'd3:    golden = alu_a | alu_b;
            3'd4:    golden = alu_a ^ alu_b;
            3'd5:    golden = alu_a << shamt;
            3'd6:    golden = alu_a >> shamt;
            default: golden = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            lfsr_reg     <= SEED;
            result_reg   <= '0;
            index_reg    <= '0;
            wait_cnt_reg <= '0;
            alu_valid    <= 1'b0;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            timeout      <= 1'b0;
            fail_count   <= '0;
            first_fail   <= 8'hFF;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg  <= ST_ISSUE;
                        lfsr_reg   <= lfsr_next;
                        index_reg  <= '0;
                        alu_a      <= a_next;
                        alu_b      <= b_next;
                        alu_op     <= 3'd0;
                        alu_valid  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        timeout    <= 1'b0;
                        fail_count <= '0;
                        first_fail <= 8'hFF;
                    end
                end
                ST_ISSUE: begin
                    alu_valid    <= 1'b0;
                    wait_cnt_reg <= '0;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_result_valid) begin
                        result_reg <= alu_result;
                        state_reg  <= ST_CHECK;
                    end else begin
                        wait_cnt_reg <= wait_inc;
                        if (wait_inc == WAIT_MAX) begin
                            timeout   <= 1'b1;
                            error     <= 1'b1;
                            done      <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_CHECK: begin
                    if (result_reg != golden) begin
                        error <= 1'b1;
                        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
                        if (first_fail == 8'hFF) first_fail <= index_reg;
                    end
                    if (index_reg == LAST_IDX) begin
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        index_reg <= index_reg + 8'd1;
                        lfsr_reg  <= lfsr_next;
                        alu_a     <= a_next;
                        alu_b     <= b_next;
                        // alu_op doubles as the index-mod-7 counter
                        alu_op    <= (alu_op == 3'd6) ? 3'd0 : alu_op + 3'd1;
                        alu_valid <= 1'b1;
                        state_reg <= ST_ISSUE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: a mock ALU with selectable misbehaviour and
// directed runs whose outcomes (cycles, flags, operands) are hand-computed.
module tb_alu_bist_driver;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         alu_valid;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic         alu_result_valid;
    logic         done;
    logic         error;
    logic         timeout;
    logic [7:0]   fail_count;
    logic [7:0]   first_fail;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // mock ALU state; mode 0 good, 1 flips bit0 on vectors 5/9, 2 silent, 3 variable latency + spurious
    int           mode    = 0;
    int           vec_num = 0;
    int           left    = 0;
    bit           in_run  = 1'b0;
    bit           pend    = 1'b0;
    bit           rv_real = 1'b0;
    bit           rv_spur = 1'b0;
    bit           real_prev;
    logic [W-1:0] res_q   = '0;
    logic [W-1:0] a_log [0:1];
    logic [W-1:0] b_log [0:1];
    logic [2:0]   op_log[0:15];

    alu_bist_driver #(
        .DATA_WIDTH (32),
        .NUM_VECTORS(16),
        .LFSR_SEED  (32'hACE1_2468),
        .TIMEOUT    (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .alu_valid       (alu_valid),
        .alu_op          (alu_op),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_result      (alu_result),
        .alu_result_valid(alu_result_valid),
        .done            (done),
        .error           (error),
        .timeout         (timeout),
        .fail_count      (fail_count),
        .first_fail      (first_fail)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_model(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        real_prev = rv_real;
        rv_real   = 1'b0;
        rv_spur   = 1'b0;
        if (reset) begin
            pend   = 1'b0;
            in_run = 1'b0;
        end else begin
            if (done) in_run = 1'b0;
            if (pend) begin
                left--;
                if (left == 0) begin
                    rv_real = 1'b1;
                    pend    = 1'b0;
                end
            end
            if (alu_valid) begin
                if (!in_run) begin
                    vec_num = 0;
                    in_run  = 1'b1;
                end
                if (vec_num < 2) begin
                    a_log[vec_num] = alu_a;
                    b_log[vec_num] = alu_b;
                end
                if (vec_num < 16) op_log[vec_num] = alu_op;
                res_q = alu_model(alu_op, alu_a, alu_b);
                if (mode == 1 && (vec_num == 5 || vec_num == 9)) res_q[0] = ~res_q[0];
                if (mode != 2) begin
                    pend = 1'b1;
                    left = (mode == 3) ? (vec_num % 5) + 1 : 1;
                end
                if (mode == 3) rv_spur = 1'b1;
                vec_num++;
            end
            if (mode == 3 && real_prev) rv_spur = 1'b1;
        end
    end

    assign alu_result_valid = rv_real | rv_spur;
    assign alu_result       = rv_spur ? ~res_q : res_q;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"}, alu_valid, 0);
        check_val({tag, "_op"}, alu_op, 0);
        check_val({tag, "_a"}, alu_a, 0);
        check_val({tag, "_b"}, alu_b, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_error"}, error, 0);
        check_val({tag, "_timeout"}, timeout, 0);
        check_val({tag, "_fail_count"}, fail_count, 0);
        check_val({tag, "_first_fail"}, first_fail, 8'hFF);
    endtask

    // start sampled at edge 0; cycle 1 is the first ISSUE; returns with done seen (or budget spent)
    task automatic run(input string tag, input int m, input int poke);
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check_val({tag, "_c1_valid"}, alu_valid, 1);
        check_val({tag, "_c1_done"}, done, 0);
        check_val({tag, "_c1_error"}, error, 0);
        check_val({tag, "_c1_fail_count"}, fail_count, 0);
        check_val({tag, "_c1_first_fail"}, first_fail, 8'hFF);
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = (poke != 0 && (cyc == poke || cyc == poke + 5)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check_val({tag, "_done"}, done, 1);
        $display("run %s mode %0d: done at cycle %0d error=%0b timeout=%0b fail_count=%0d first_fail=%0h",
                 tag, m, cyc, error, timeout, fail_count, first_fail);
    endtask

    task automatic check_result(input string tag, input int exp_cyc, input logic exp_err,
                                input logic exp_to, input int exp_fc, input int exp_ff,
                                input int exp_issued);
        check_val({tag, "_done_cycle"}, cyc, exp_cyc);
        check_val({tag, "_error"}, error, exp_err);
        check_val({tag, "_timeout"}, timeout, exp_to);
        check_val({tag, "_fail_count"}, fail_count, exp_fc);
        check_val({tag, "_first_fail"}, first_fail, exp_ff);
        check_val({tag, "_issued"}, vec_num, exp_issued);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        // start together with reset: reset must win
        start = 1'b1;
        @(negedge clk);
        check_val("por_start_ignored_valid", alu_valid, 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        run("good", 0, 0);
        check_result("good", 49, 1'b0, 1'b0, 0, 8'hFF, 16);
        check_val("good_a0", a_log[0], 32'hACE1_2468);
        check_val("good_b0", b_log[0], 32'h5670_9234);
        check_val("good_op0", op_log[0], 0);
        check_val("good_a1", a_log[1], 32'h2B38_491A);
        check_val("good_b1", b_log[1], 32'h159C_248D);
        check_val("good_op1", op_log[1], 1);
        check_val("good_op6", op_log[6], 6);
        check_val("good_op7", op_log[7], 0);
        check_val("good_op15", op_log[15], 1);
        repeat (3) @(negedge clk);
        check_val("good_done_sticky", done, 1);
        check_val("good_idle_valid", alu_valid, 0);

        run("flip", 1, 0);
        check_result("flip", 49, 1'b1, 1'b0, 2, 5, 16);

        run("poke", 0, 20);
        check_result("poke", 49, 1'b0, 1'b0, 0, 8'hFF, 16);
        check_val("poke_a0", a_log[0], 32'hACE1_2468);

        run("silent", 2, 0);
        check_result("silent", 66, 1'b1, 1'b1, 0, 8'hFF, 1);

        run("varlat", 3, 0);
        check_result("varlat", 79, 1'b0, 1'b0, 0, 8'hFF, 16);

        // reset during WAIT of vector 7 (ISSUE at cycle 22, WAIT at cycle 23)
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 23) begin
            @(negedge clk);
            cyc++;
        end
        check_val("rst_issued_before", vec_num, 8);
        check_val("rst_op7", alu_op, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_val("midrst_no_done", done, 0);
        check_val("midrst_no_valid", alu_valid, 0);
        $display("reset applied in WAIT of vector 7; outputs back to reset values");

        run("rerun", 0, 0);
        check_result("rerun", 49, 1'b0, 1'b0, 0, 8'hFF, 16);
        check_val("rerun_a0", a_log[0], 32'hACE1_2468);
        check_val("rerun_op0", op_log[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_bist_driver.md
# alu_bist_driver

Built-in self-test driver for the W0RM ALU core. It is the producing end of the `done`/`error` status interface that the ALU testbench aggregator consumes. On `start` it generates a fixed, seed-determined sequence of operations and issues them to the ALU. It checks every result against an internal golden model and reports `done`/`error` plus diagnostics, so the same self-check runs in simulation and on the FPGA.

## Interface

Parameters:
- `DATA_WIDTH`, 32: ALU operand and result width. Minimum 8.
- `NUM_VECTORS`, 16: vectors per run, 1..255.
- `LFSR_SEED`, 32'hACE1_2468: operand LFSR seed. A zero value is replaced by 1.
- `TIMEOUT`, 64: maximum cycles spent in WAIT per vector, 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: starts a run. Sampled only in IDLE or DONE.
- `alu_valid` out 1: single-cycle strobe that issues one operation.
- `alu_op` out 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical).
- `alu_a`, `alu_b` out DATA_WIDTH: operands. Held stable from ISSUE through CHECK.
- `alu_result` in DATA_WIDTH: ALU result.
- `alu_result_valid` in 1: result qualifier.
- `done` out 1: run finished. Sticky until the next start or reset.
- `error` out 1: at least one mismatch, or a timeout. Valid when `done`=1.
- `timeout` out 1: the run was aborted by a timeout.
- `fail_count` out 8: number of mismatches, saturates at 255.
- `first_fail` out 8: index of the first failing vector. 8'hFF if none.

## Operation

- FSM states are IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE or DONE with `start`=1 → ISSUE. On this transition:
  - LFSR ← seed; vector index ← 0.
  - `done`, `error`, `timeout` ← 0; `fail_count` ← 0; `first_fail` ← FF.
  - `alu_a` ← current LFSR value; the LFSR advances; `alu_b` ← the new LFSR value; the LFSR advances again.
  - `alu_op` ← index mod 7.
- ISSUE: `alu_valid`=1 for exactly one cycle. Next state is WAIT, and the wait counter clears.
- WAIT:
  - If `alu_result_valid`=1, latch `alu_result` and go to CHECK.
  - Otherwise the wait counter increments. When it reaches TIMEOUT, set `timeout`=1 and `error`=1, then go to DONE.
- CHECK: compare the latched result with the golden result.
  - On mismatch: `error` ← 1; `fail_count` increments (saturating); if `first_fail`=FF, `first_fail` ← index.
  - If index = NUM_VECTORS−1, go to DONE with `done` ← 1.
  - Otherwise: index increments, the next operands and op load as above, and the next state is ISSUE.
- Golden model, all results truncated to DATA_WIDTH:
  - ADD: a+b. SUB: a−b.
  - AND, OR, XOR: bitwise.
  - SHL: a << b[log2(DATA_WIDTH)−1:0]. SHR: a >> b[log2(DATA_WIDTH)−1:0], zero fill.
- LFSR: Galois, DATA_WIDTH bits. For 32 bits the taps are x^32+x^22+x^2+x+1. It shifts right; when the LSB is 1, XOR with mask 32'h8020_0003.
- `start` in ISSUE, WAIT or CHECK is ignored.
- `alu_result_valid` in IDLE, ISSUE, CHECK or DONE is ignored.

## Timing

- Reset values: state IDLE; `alu_valid`, `alu_op`, `alu_a`, `alu_b` all 0; `done`, `error`, `timeout` 0; `fail_count` 0; `first_fail` FF.
- Reset asserted mid-run: takes effect at the next edge and aborts the run with no done pulse.
- Reset and `start` in the same cycle: reset wins.
- Per vector with a 1-cycle ALU (result valid in the first WAIT cycle): 3 cycles (ISSUE, WAIT, CHECK).
- With `start` sampled at edge 0, the first ISSUE is cycle 1. For NUM_VECTORS=16, `done` rises at cycle 49.
- Result arriving k cycles after ISSUE (k ≥ 1): that vector takes k+2 cycles.
- Timeout: WAIT lasts TIMEOUT cycles, then `done`=`error`=`timeout`=1 on the following cycle.
- `start` held high continuously re-triggers from DONE. Each run still shows `done`=1 for one cycle before the new run clears it.

## Test plan

- Correct mock ALU with 1-cycle latency, defaults, one `start` pulse → `alu_valid` pulses 16 times; `done`=1 at cycle 49; `error`=0; `fail_count`=0; `first_fail`=FF; first operands are `alu_a`=32'hACE1_2468 and `alu_op`=0.
- Mock ALU that flips bit 0 of the result on vectors 5 and 9 → `done`=1, `error`=1, `fail_count`=2, `first_fail`=5, `timeout`=0.
- Mock ALU that never asserts `alu_result_valid` → the first WAIT lasts 64 cycles; `done`=`error`=`timeout`=1 at cycle 66; `fail_count`=0.
- Mock ALU with variable latency 1..5 plus spurious `alu_result_valid` during ISSUE and CHECK → no mismatches, and the spurious strobes are ignored.
- `reset` asserted during WAIT of vector 7 → all outputs return to reset values on the next cycle; a new `start` reruns from vector 0 with `alu_a`=32'hACE1_2468.
- Extra `start` pulses mid-run → no effect. `start` after `done` → `done`, `error` and `fail_count` clear and a full second run passes identically.
